sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock, parameterized first-in-first-out buffer with full/empty status flags.
- Used as a rate/elasticity buffer between a producer and a consumer in the same clock domain.
- Instantiated at DEPTH=8, DATA_WIDTH=8 in the system bench, which exercises empty/full boundaries through an interface bundle.

Parameters:
- DEPTH, 8, number of storage entries; power of two, >= 2.
- DATA_WIDTH, 8, bit width of each entry.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- w_en  input  1  write request.
- r_en  input  1  read request.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data; registered.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when 0 entries are stored.

Behaviour:
- Pointers:
  - Write pointer and read pointer are each log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (wptr == rptr).
  - full = (address bits equal) and (wrap bits differ).
  - Both flags are combinational decodes of the registered pointers, so they update in the same cycle as the pointer change.
- Reset (rst_n low, asynchronous): wptr=0, rptr=0, data_out=0, therefore empty=1, full=0. Storage contents are not reset (don't-care).
- Reset mid-operation: all contents are discarded immediately; the FIFO reads back empty after rst_n deasserts.
- Write:
  - Accepted on a rising clk edge when w_en=1 and full=0.
  - mem[wptr] <= data_in; wptr increments by 1.
  - w_en while full is ignored: no state change, no data corruption.
- Read:
  - Accepted on a rising clk edge when r_en=1 and empty=0.
  - data_out <= mem[rptr]; rptr increments by 1.
  - Data is visible on data_out one cycle after the read-request edge.
  - r_en while empty is ignored: data_out holds its last value.
- Flags use pre-edge values. When w_en and r_en are both high:
  - Not full and not empty: both operations happen; occupancy is unchanged.
  - Full: only the read happens; full drops next cycle.
  - Empty: only the write happens; data_out is unchanged; empty drops next cycle.
- Wrap-around: pointers roll over modulo 2*DEPTH naturally. Ordering is preserved across any number of wraps.
- data_out changes only on an accepted read or on reset.

Optional Feature:
- Macro: SYNC_FIFO_COUNT_EN.
- When defined:
  - Adds output port count, width log2(DEPTH)+1, giving the current occupancy 0..DEPTH.
  - count = wptr - rptr (modulo 2*DEPTH), combinational from the pointers.
  - count resets to 0.
- When undefined: the count port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sync_fifo_pkg holds:
  - default constants FIFO_DEPTH_DEF=8 and FIFO_WIDTH_DEF=8;
  - a function or localparam pattern for pointer width = $clog2(DEPTH)+1.
- One natural sub-module: sync_fifo_mem, a DEPTH x DATA_WIDTH register array with a synchronous write port and an addressed read.
- Pointer and flag logic stay in sync_fifo.

Test Plan:
- Reset then idle -> empty=1, full=0, data_out=0. Issue r_en=1 for 3 cycles -> empty stays 1, data_out stays 0.
- Write 0x01..0x08 on consecutive cycles -> full=1 after the 8th edge, empty=0. A 9th write of 0xFF is ignored.
- From full, read 8 times -> data_out = 0x01..0x08 in order, each one cycle after its read edge. empty=1 after the 8th read. A 9th read leaves data_out=0x08.
- Fill with 5 entries, then hold w_en=r_en=1 for 10 cycles with incrementing data -> occupancy stays 5 and output order is preserved across the pointer wrap.
- At full, assert w_en and r_en together -> one entry read, the write is dropped, full=0 next cycle. At empty, assert both -> the write lands, data_out unchanged, empty=0 next cycle.
- Write 4 entries, then pulse rst_n low between clock edges -> empty=1 and data_out=0 immediately. After release, a read returns nothing (empty stays 1). With SYNC_FIFO_COUNT_EN defined, count=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-width helper for the sync_fifo block.
// Optional occupancy output is enabled by defining SYNC_FIFO_COUNT_EN.
package sync_fifo_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FIFO_WIDTH_DEF = 8;

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo; count is present only when
// SYNC_FIFO_COUNT_EN is defined.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  parameter int DATA_WIDTH = FIFO_WIDTH_DEF
) ();

  localparam int PTR_W = ptr_width(DEPTH);

  // Handshake: a write transfers on a rising edge where w_en=1 and full=0;
  // a read transfers on a rising edge where r_en=1 and empty=0, with the
  // word appearing on data_out after that edge. Requests against the
  // blocking flag are dropped, never queued.
  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
`ifdef SYNC_FIFO_COUNT_EN
  logic [PTR_W-1:0]      count;
`endif

`ifdef SYNC_FIFO_COUNT_EN
  modport master (output w_en, r_en, data_in, input data_out, full, empty, count);
  modport slave  (input w_en, r_en, data_in, output data_out, full, empty, count);
`else
  modport master (output w_en, r_en, data_in, input data_out, full, empty);
  modport slave  (input w_en, r_en, data_in, output data_out, full, empty);
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, addressed read.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  parameter int DATA_WIDTH = FIFO_WIDTH_DEF,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and combinational full/empty.
// Define SYNC_FIFO_COUNT_EN to expose the occupancy on bus.count.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  parameter int DATA_WIDTH = FIFO_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int AW    = PTR_W - 1;

  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign wr_ok = bus.w_en && !full;
  assign rd_ok = bus.r_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      data_q <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_W'(1);
      if (rd_ok) begin
        rptr   <= rptr + PTR_W'(1);
        data_q <= rd_data;
      end
    end
  end

  sync_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (bus.data_in),
    .raddr (rptr[AW-1:0]),
    .rdata (rd_data)
  );

  assign bus.data_out = data_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
`ifdef SYNC_FIFO_COUNT_EN
  // Modulo subtraction of the wrap-bit pointers yields 0..DEPTH directly.
  assign bus.count    = wptr - rptr;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo at DEPTH=8, DATA_WIDTH=8.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic clk;
  logic rst_n;

  sync_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: stored contents, read-result queue, held output
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout;

  typedef struct {
    logic          w;
    logic          r;
    logic [DW-1:0] din;
    logic          exp_full;
    logic          exp_empty;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive, take one rising edge, check, return at negedge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit wr_ok, rd_ok;
    logic [DW-1:0] e;
    bus.w_en    = w;
    bus.r_en    = r;
    bus.data_in = d;
    wr_ok = w && (mq.size() < DEPTH);
    rd_ok = r && (mq.size() > 0);
    if (rd_ok) exp_q.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(d);
    @(posedge clk);
    #1;
    if (rd_ok) begin
      e = exp_q.pop_front();
      chk("sb_data_out", bus.data_out, e);
      exp_dout = e;
    end else begin
      chk("hold_data_out", bus.data_out, exp_dout);
    end
    chk("full", bus.full, (mq.size() == DEPTH));
    chk("empty", bus.empty, (mq.size() == 0));
`ifdef SYNC_FIFO_COUNT_EN
    chk("count", bus.count, mq.size());
`endif
    @(negedge clk);
  endtask

  initial begin
    // vector table: idle reads, 8 writes + dropped 9th, 8 reads + ignored 9th
    for (int i = 0; i < 3; i++)
      vecs[i] = '{w:1'b0, r:1'b1, din:8'h00, exp_full:1'b0, exp_empty:1'b1, exp_dout:8'h00};
    for (int i = 1; i <= 8; i++)
      vecs[2+i] = '{w:1'b1, r:1'b0, din:DW'(i), exp_full:(i == 8), exp_empty:1'b0, exp_dout:8'h00};
    vecs[11] = '{w:1'b1, r:1'b0, din:8'hFF, exp_full:1'b1, exp_empty:1'b0, exp_dout:8'h00};
    for (int i = 1; i <= 8; i++)
      vecs[11+i] = '{w:1'b0, r:1'b1, din:8'h00, exp_full:1'b0, exp_empty:(i == 8), exp_dout:DW'(i)};
    vecs[20] = '{w:1'b0, r:1'b1, din:8'h00, exp_full:1'b0, exp_empty:1'b1, exp_dout:8'h08};

    rst_n       = 1'b0;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;
    exp_dout    = '0;
    @(negedge clk);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_data_out", bus.data_out, 8'h00);
`ifdef SYNC_FIFO_COUNT_EN
    chk("rst_count", bus.count, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].w, vecs[i].r, vecs[i].din);
      chk($sformatf("vec%0d_full", i), bus.full, vecs[i].exp_full);
      chk($sformatf("vec%0d_empty", i), bus.empty, vecs[i].exp_empty);
      chk($sformatf("vec%0d_dout", i), bus.data_out, vecs[i].exp_dout);
    end

    // steady-state occupancy of 5 with simultaneous traffic across the wrap
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, DW'(8'h20 + i));
      chk("wrap_not_full", bus.full, 1'b0);
      chk("wrap_not_empty", bus.empty, 1'b0);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
    chk("wrap_last", bus.data_out, 8'h29);
    chk("wrap_drained", bus.empty, 1'b1);

    // both requests at full: read only, write dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(8'h40 + i));
    chk("full_before_both", bus.full, 1'b1);
    step(1'b1, 1'b1, 8'hAA);
    chk("full_both_dout", bus.data_out, 8'h40);
    chk("full_both_full", bus.full, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00);
    chk("full_both_dropped", bus.data_out, 8'h47);
    chk("full_both_empty", bus.empty, 1'b1);

    // both requests at empty: write only, data_out held
    step(1'b1, 1'b1, 8'h55);
    chk("empty_both_dout", bus.data_out, 8'h47);
    chk("empty_both_empty", bus.empty, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    chk("empty_both_read", bus.data_out, 8'h55);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));

    // asynchronous reset mid-operation, pulsed between clock edges
    while (mq.size() > 0) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'hC0 + i));
    step(1'b0, 1'b1, 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_empty", bus.empty, 1'b1);
    chk("async_rst_full", bus.full, 1'b0);
    chk("async_rst_dout", bus.data_out, 8'h00);
`ifdef SYNC_FIFO_COUNT_EN
    chk("async_rst_count", bus.count, 0);
`endif
    #1;
    rst_n = 1'b1;
    mq.delete();
    exp_q.delete();
    exp_dout = '0;
    @(negedge clk);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_empty", bus.empty, 1'b1);
    chk("post_rst_dout", bus.data_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
